usb_tx_pkt_ctrl: RTL
====================

Name: usb_tx_pkt_ctrl

Overview:
Parametrised USB transmit packet sequencer. It is the next-generation controller that drives the parallel-to-serial shifter, the CRC16 unit and the TX data buffer.
- Sequences the byte stream SYNC, PID, payload, CRC16 and EOP.
- Adds over the previous generation: configurable SYNC length and maximum payload, zero-length DATA packets, a STALL handshake, automatic DATA0/DATA1 toggling, request validation and mid-packet abort.

Parameters:
MAX_LEN, 64, maximum payload bytes accepted per DATA packet.
LEN_W, 7, width of tx_len and of the byte counter; 2**LEN_W must exceed MAX_LEN.
SYNC_BYTES, 1, number of SYNC bytes: (SYNC_BYTES-1) bytes of 8'h00, then one byte of 8'h80.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
tx_start  in  1  one-cycle request strobe, sampled only in IDLE.
tx_type  in  3  0=DATA0, 1=DATA1, 2=ACK, 3=NAK, 4=STALL, 5=DATA_AUTO; 6 and 7 reserved.
tx_len  in  LEN_W  payload byte count, used for DATA types only.
tx_abort  in  1  terminate the current packet early.
toggle_clr  in  1  force the data toggle to 0.
buf_data  in  8  head byte of the TX buffer, valid combinationally.
buf_rd  out  1  pops the buffer head, one-cycle pulse.
ld_byte  out  1  loads ld_data into the shifter, one-cycle pulse.
ld_data  out  8  byte presented to the shifter, LSB transmitted first.
byte_done  in  1  shifter pulse: last loaded byte fully shifted out.
eop_req  out  1  one-cycle pulse requesting the encoder to emit SE0,SE0,J.
eop_done  in  1  encoder pulse: EOP complete.
crc_clr  out  1  clears the CRC16 unit.
crc_en  out  1  CRC16 consumes ld_data this cycle.
crc_in  in  16  finalised CRC16 from the CRC unit.
busy  out  1  high in any state other than IDLE.
phase  out  3  0=IDLE, 1=SYNC, 2=PID, 3=DATA, 4=CRC_LO, 5=CRC_HI, 6=EOP, 7=DONE.
toggle  out  1  current data toggle.
tx_done  out  1  one-cycle completion pulse.
tx_aborted  out  1  qualifies tx_done; high if the packet was aborted.
tx_err  out  1  one-cycle pulse: request rejected.

Behaviour:
- All outputs are registered.
- Reset: every output is 0, the state is IDLE, the byte counter is 0, latched type/length are 0 and toggle is 0.
- Reset mid-packet abandons the packet immediately. No tx_done, no eop_req.

IDLE:
- A request is tx_start=1 in IDLE. tx_start is ignored in all other states.
- Reject if tx_type is 6 or 7, or if the type is DATA and tx_len > MAX_LEN. On reject: tx_err=1 on the next cycle, state stays IDLE.
- Otherwise latch type and length, pulse crc_clr, and go to SYNC on the next cycle.
- DATA_AUTO resolves its PID from toggle at accept time.

Byte states (SYNC, PID, DATA, CRC_LO, CRC_HI):
- ld_byte is asserted with ld_data in the first cycle of each byte.
- The next byte loads in the cycle after byte_done.
- byte_done is ignored in the load cycle itself.

SYNC:
- Emits SYNC_BYTES bytes, counted by the byte counter.
- After the byte_done of the last SYNC byte, go to PID.

PID:
- ld_data = {~pid, pid}: DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
- After byte_done:
  - handshake types go to EOP;
  - DATA with len=0 goes to CRC_LO;
  - otherwise go to DATA with the counter reset to 0.

DATA:
- In each load cycle: buf_rd=1, crc_en=1, ld_data=buf_data.
- After byte_done, the counter increments.
- At counter==len, go to CRC_LO; otherwise load the next byte.

CRC_LO / CRC_HI:
- CRC_LO sends crc_in[7:0]; CRC_HI then sends crc_in[15:8]. Then go to EOP.
- crc_en is 0 in both.

EOP:
- eop_req pulses in the first cycle; then wait for eop_done, then go to DONE.

DONE:
- tx_done=1 for one cycle, then IDLE.
- If the type was DATA_AUTO and the packet was not aborted, toggle flips in this cycle.

Abort:
- tx_abort=1 in any byte state goes to EOP on the next cycle, without waiting for byte_done.
- No further buf_rd is issued. tx_aborted=1 alongside tx_done.
- tx_abort is ignored in IDLE, EOP and DONE.

toggle_clr:
- Has priority over a simultaneous flip in DONE.

Counter width:
- LEN_W bits, never wraps, since len <= MAX_LEN < 2**LEN_W.

Test Plan:
- ACK, SYNC_BYTES=1: tx_start, type=2 -> ld_data 8'h80 then 8'hD2, eop_req; after eop_done, tx_done=1 with tx_aborted=0; no buf_rd, no crc_en.
- DATA0, len=3, buffer 8'h01,8'h02,8'h03, crc_in=16'hABCD -> byte sequence 80,C3,01,02,03,CD,AB; exactly 3 buf_rd and 3 crc_en pulses, crc_clr once at accept.
- DATA_AUTO twice then toggle_clr, len=0 -> PIDs C3 then 4B, toggle reads 1 then 0 after each tx_done; second packet sends only crc_in bytes after PID; after toggle_clr, toggle=0.
- SYNC_BYTES=4, STALL -> bytes 00,00,00,80,1E; phase sequence 1,2,6,7,0.
- Reject: type=7, and DATA0 with len=MAX_LEN+1 -> tx_err pulse each, busy stays 0; tx_start during an active packet -> ignored.
- Abort: DATA1 len=8, tx_abort during 3rd payload byte -> eop_req next cycle, total buf_rd=3, tx_done with tx_aborted=1, toggle unchanged; rst mid-payload -> all outputs 0, next request behaves normally.

Source files
------------

// File: rtl/usb_tx_pkt_ctrl.sv
// USB transmit packet sequencer: drives SYNC, PID, payload, CRC16 and EOP into the
// shifter/encoder with DATA0/DATA1 auto-toggle, request validation and abort.
module usb_tx_pkt_ctrl #(
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = 7,
    parameter int SYNC_BYTES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tx_start,
    input  logic [2:0]       i_tx_type,
    input  logic [LEN_W-1:0] i_tx_len,
    input  logic             i_tx_abort,
    input  logic             i_toggle_clr,
    input  logic [7:0]       i_buf_data,
    output logic             o_buf_rd,
    output logic             o_ld_byte,
    output logic [7:0]       o_ld_data,
    input  logic             i_byte_done,
    output logic             o_eop_req,
    input  logic             i_eop_done,
    output logic             o_crc_clr,
    output logic             o_crc_en,
    input  logic [15:0]      i_crc_in,
    output logic             o_busy,
    output logic [2:0]       o_phase,
    output logic             o_toggle,
    output logic             o_tx_done,
    output logic             o_tx_aborted,
    output logic             o_tx_err
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_PID    = 3'd2,
        S_DATA   = 3'd3,
        S_CRC_LO = 3'd4,
        S_CRC_HI = 3'd5,
        S_EOP    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LAST_SYNC = LEN_W'(SYNC_BYTES - 1);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [2:0]       r_type;
    logic             r_auto;
    logic             r_aborted;

    logic             w_byte_st;
    logic             w_done_evt;
    logic             w_data_req;
    logic             w_reject;
    logic [LEN_W-1:0] w_cnt_nxt;

    // o_ld_byte marks the load cycle, where byte_done is not yet meaningful
    assign w_byte_st  = (r_state != S_IDLE) && (r_state < S_EOP);
    assign w_done_evt = w_byte_st && !o_ld_byte && i_byte_done;
    assign w_data_req = (i_tx_type == 3'd0) || (i_tx_type == 3'd1) || (i_tx_type == 3'd5);
    assign w_reject   = (i_tx_type[2:1] == 2'b11) || (w_data_req && (i_tx_len > MAX_L));
    assign w_cnt_nxt  = r_cnt + ONE;
    assign o_phase    = r_state;

    function automatic logic [7:0] f_pid(input logic [2:0] t);
        case (t)
            3'd0:    f_pid = 8'hC3;
            3'd1:    f_pid = 8'h4B;
            3'd2:    f_pid = 8'hD2;
            3'd3:    f_pid = 8'h5A;
            default: f_pid = 8'h1E;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            r_type       <= '0;
            r_auto       <= 1'b0;
            r_aborted    <= 1'b0;
            o_buf_rd     <= 1'b0;
            o_ld_byte    <= 1'b0;
            o_ld_data    <= 8'h00;
            o_eop_req    <= 1'b0;
            o_crc_clr    <= 1'b0;
            o_crc_en     <= 1'b0;
            o_busy       <= 1'b0;
            o_toggle     <= 1'b0;
            o_tx_done    <= 1'b0;
            o_tx_aborted <= 1'b0;
            o_tx_err     <= 1'b0;
        end else begin
            o_buf_rd     <= 1'b0;
            o_ld_byte    <= 1'b0;
            o_eop_req    <= 1'b0;
            o_crc_clr    <= 1'b0;
            o_crc_en     <= 1'b0;
            o_tx_done    <= 1'b0;
            o_tx_aborted <= 1'b0;
            o_tx_err     <= 1'b0;

            if (r_state == S_IDLE) begin
                if (i_tx_start) begin
                    if (w_reject) begin
                        o_tx_err <= 1'b1;
                    end else begin
                        r_auto    <= (i_tx_type == 3'd5);
                        r_type    <= (i_tx_type == 3'd5) ? {2'b00, o_toggle} : i_tx_type;
                        r_len     <= i_tx_len;
                        r_cnt     <= '0;
                        r_aborted <= 1'b0;
                        o_crc_clr <= 1'b1;
                        o_busy    <= 1'b1;
                        o_ld_byte <= 1'b1;
                        o_ld_data <= (SYNC_BYTES == 1) ? 8'h80 : 8'h00;
                        r_state   <= S_SYNC;
                    end
                end
            end else if (w_byte_st && i_tx_abort) begin
                r_aborted <= 1'b1;
                o_eop_req <= 1'b1;
                r_state   <= S_EOP;
            end else if (w_done_evt) begin
                o_ld_byte <= 1'b1;
                case (r_state)
                    S_SYNC: begin
                        if (r_cnt == LAST_SYNC) begin
                            o_ld_data <= f_pid(r_type);
                            r_state   <= S_PID;
                        end else begin
                            r_cnt     <= w_cnt_nxt;
                            o_ld_data <= (w_cnt_nxt == LAST_SYNC) ? 8'h80 : 8'h00;
                        end
                    end
                    S_PID: begin
                        if (r_type >= 3'd2) begin
                            o_ld_byte <= 1'b0;
                            o_eop_req <= 1'b1;
                            r_state   <= S_EOP;
                        end else if (r_len == '0) begin
                            o_ld_data <= i_crc_in[7:0];
                            r_state   <= S_CRC_LO;
                        end else begin
                            r_cnt     <= '0;
                            o_ld_data <= i_buf_data;
                            o_buf_rd  <= 1'b1;
                            o_crc_en  <= 1'b1;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            o_ld_data <= i_crc_in[7:0];
                            r_state   <= S_CRC_LO;
                        end else begin
                            o_ld_data <= i_buf_data;
                            o_buf_rd  <= 1'b1;
                            o_crc_en  <= 1'b1;
                        end
                    end
                    S_CRC_LO: begin
                        o_ld_data <= i_crc_in[15:8];
                        r_state   <= S_CRC_HI;
                    end
                    default: begin
                        o_ld_byte <= 1'b0;
                        o_eop_req <= 1'b1;
                        r_state   <= S_EOP;
                    end
                endcase
            end else if (r_state == S_EOP) begin
                if (!o_eop_req && i_eop_done) begin
                    o_tx_done    <= 1'b1;
                    o_tx_aborted <= r_aborted;
                    r_state      <= S_DONE;
                end
            end else if (r_state == S_DONE) begin
                o_busy  <= 1'b0;
                r_state <= S_IDLE;
                if (r_auto && !r_aborted)
                    o_toggle <= ~o_toggle;
            end

            if (i_toggle_clr)
                o_toggle <= 1'b0;
        end
    end
endmodule
